// File: rtl/counter32_rev_pkg.sv
// Shared constants for the loadable up/down counter.
package counter32_rev_pkg;

    localparam int unsigned CNT_WIDTH = 32;

endpackage : counter32_rev_pkg

// File: rtl/counter32_rev_if.sv
// Control and status bundle for counter32_rev: the master drives direction/load, the slave returns count and ripple flag.
interface counter32_rev_if
    import counter32_rev_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
);

    logic             s;
    logic             Load;
    logic [WIDTH-1:0] pData;
    logic [WIDTH-1:0] cnt;
    logic             Rc;

    modport master (
        output s,
        output Load,
        output pData,
        input  cnt,
        input  Rc
    );

    modport slave (
        input  s,
        input  Load,
        input  pData,
        output cnt,
        output Rc
    );

endinterface : counter32_rev_if

// File: rtl/counter32_rev.sv
// Loadable up/down binary counter with a combinational ripple carry/borrow flag for cascading.
module counter32_rev
    import counter32_rev_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    counter32_rev_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;

    // Priority: reset, then load, then count in the direction of s.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.Load) begin
            cnt_q <= bus.pData;
        end else if (bus.s) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end else begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign bus.cnt = cnt_q;

    // Flags the cycle whose next count wraps; follows s with no register stage.
    assign bus.Rc = (bus.s & (cnt_q == ALL_ONES)) | (~bus.s & (cnt_q == '0));

endmodule : counter32_rev

// File: tb/tb_counter32_rev.sv
// Directed bench for counter32_rev: arithmetic reference model compared every cycle plus literal checkpoints.
module tb_counter32_rev;
    import counter32_rev_pkg::*;

    localparam longint unsigned MODULUS = 64'h1_0000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    counter32_rev_if #(.WIDTH(CNT_WIDTH)) bus ();

    counter32_rev #(.WIDTH(CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value of the count as an unbounded integer reduced modulo 2^32.
    longint unsigned model_cnt;
    bit              model_valid;

    always @(posedge clk) begin
        if (rst) begin
            model_cnt   = 0;
            model_valid = 1'b1;
        end else if (bus.Load) begin
            model_cnt = longint'(bus.pData);
        end else if (bus.s) begin
            model_cnt = (model_cnt + 1) % MODULUS;
        end else begin
            model_cnt = (model_cnt + MODULUS - 1) % MODULUS;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_cnt", bus.cnt, 32'(model_cnt));
            chk("model_rc", 32'(bus.Rc),
                32'(bus.s ? (model_cnt == MODULUS - 1) : (model_cnt == 0)));
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] e;
        checks      = 0;
        errors      = 0;
        model_valid = 1'b0;
        model_cnt   = 0;
        rst         = 1'b1;
        bus.s       = 1'b0;
        bus.Load    = 1'b0;
        bus.pData   = '0;

        // Reset for two edges, then Rc must follow s without an edge.
        edge_step();
        edge_step();
        chk("reset_cnt", bus.cnt, 32'h0);
        chk("reset_rc_down", 32'(bus.Rc), 32'd1);
        bus.s = 1'b1;
        #1;
        chk("reset_rc_up", 32'(bus.Rc), 32'd0);
        rst = 1'b0;

        // Load 6 and count down through zero.
        bus.s     = 1'b0;
        bus.pData = 32'd6;
        bus.Load  = 1'b1;
        edge_step();
        bus.Load = 1'b0;
        chk("load6", bus.cnt, 32'd6);
        for (int k = 5; k >= 0; k--) begin
            edge_step();
            chk("down_cnt", bus.cnt, 32'(k));
            chk("down_rc", 32'(bus.Rc), 32'(k == 0));
        end
        edge_step();
        chk("down_wrap", bus.cnt, 32'hFFFF_FFFF);
        chk("down_wrap_rc", 32'(bus.Rc), 32'd0);

        // Load sweep with pData scrambled after each load edge.
        p = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bus.pData = p;
            bus.Load  = 1'b1;
            bus.s     = 1'b0;
            edge_step();
            bus.Load  = 1'b0;
            bus.pData = $urandom;
            chk("sweep_load", bus.cnt, p);
            edge_step();
            e = p - 32'd1;
            chk("sweep_m1", bus.cnt, e);
            edge_step();
            e = p - 32'd2;
            chk("sweep_m2", bus.cnt, e);
            if (i == 0) chk("sweep0_lit", bus.cnt, 32'hFFFF_FFFE);
            if (i == 31) chk("sweep31_lit", p, 32'hFFFF_FFFE);
            p = (p + 32'd1) * 32'd2;
        end

        // Up wrap.
        bus.s     = 1'b1;
        bus.pData = 32'hFFFF_FFFE;
        bus.Load  = 1'b1;
        edge_step();
        bus.Load = 1'b0;
        chk("up_load", bus.cnt, 32'hFFFF_FFFE);
        chk("up_load_rc", 32'(bus.Rc), 32'd0);
        edge_step();
        chk("up_max", bus.cnt, 32'hFFFF_FFFF);
        chk("up_max_rc", 32'(bus.Rc), 32'd1);
        edge_step();
        chk("up_wrap", bus.cnt, 32'h0);
        chk("up_wrap_rc", 32'(bus.Rc), 32'd0);

        // Reset beats load; load beats count.
        rst       = 1'b1;
        bus.Load  = 1'b1;
        bus.pData = 32'h1234_5678;
        edge_step();
        chk("prio_rst", bus.cnt, 32'h0);
        rst   = 1'b0;
        bus.s = 1'b1;
        edge_step();
        bus.Load = 1'b0;
        chk("prio_load", bus.cnt, 32'h1234_5678);

        // Direction flip with no dead cycle.
        bus.pData = 32'd10;
        bus.Load  = 1'b1;
        edge_step();
        bus.Load = 1'b0;
        repeat (3) edge_step();
        chk("flip_up", bus.cnt, 32'd13);
        bus.s = 1'b0;
        repeat (3) edge_step();
        chk("flip_down", bus.cnt, 32'd10);

        // Reset mid-count, then counting resumes on the next edge.
        rst = 1'b1;
        edge_step();
        chk("mid_rst", bus.cnt, 32'h0);
        rst   = 1'b0;
        bus.s = 1'b1;
        edge_step();
        chk("after_rst", bus.cnt, 32'd1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter32_rev
